// File: rtl/rtc_edit_sequencer.sv
// Edit-datapath controller for the RTC display: BCD shadow registers with range-checked
// up/down editing, and req/ack write-back of the edited fields to the RTC bus controller.
module rtc_edit_sequencer #(
  parameter logic [7:0] AddrTimerBase = 8'h41,
  parameter logic [7:0] AddrDateBase  = 8'h24,
  parameter logic [7:0] AddrTimeBase  = 8'h21
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] mode_i,
  input  logic [1:0] field_i,
  input  logic       btn_up_i,
  input  logic       btn_down_i,
  input  logic       load_en_i,
  input  logic [7:0] ld_f0_i,
  input  logic [7:0] ld_f1_i,
  input  logic [7:0] ld_f2_i,
  input  logic       wr_ack_i,
  output logic       wr_req_o,
  output logic [7:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic [7:0] f0_o,
  output logic [7:0] f1_o,
  output logic [7:0] f2_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {StIdle, StEdit, StWrSetup, StWrWait} state_e;

  state_e          state_q, state_d;
  logic [1:0]      act_mode_q, act_mode_d;
  logic [2:0]      dirty_q, dirty_d;
  logic [2:0][7:0] shadow_q, shadow_d;
  logic            wr_req_q, wr_req_d;
  logic [7:0]      wr_addr_q, wr_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;

  logic       is_date;
  logic [7:0] sel_val, rng_min, rng_max, new_val, base_addr;
  logic [1:0] wr_idx;

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  // Out-of-range or non-BCD values (e.g. a bad RTC read) snap to the wrap target.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (!is_bcd(v) || (v >= hi)) return lo;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return v + 8'd1;
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lo,
                                         input logic [7:0] hi);
    if (!is_bcd(v) || (v <= lo) || (v > hi)) return hi;
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    return v - 8'd1;
  endfunction

  assign is_date = (act_mode_q == 2'b10);

  always_comb begin
    sel_val = 8'h00;
    rng_min = 8'h00;
    rng_max = 8'h59;
    case (field_i)
      2'b01: begin
        sel_val = shadow_q[0];
        rng_max = is_date ? 8'h99 : 8'h59;
      end
      2'b10: begin
        sel_val = shadow_q[1];
        rng_min = is_date ? 8'h01 : 8'h00;
        rng_max = is_date ? 8'h12 : 8'h59;
      end
      2'b11: begin
        sel_val = shadow_q[2];
        rng_min = is_date ? 8'h01 : 8'h00;
        rng_max = is_date ? 8'h31 : 8'h23;
      end
      default: ;
    endcase
    new_val = btn_up_i ? bcd_inc(sel_val, rng_min, rng_max) : bcd_dec(sel_val, rng_min, rng_max);
  end

  always_comb begin
    base_addr = 8'h00;
    case (act_mode_q)
      2'b01:   base_addr = AddrTimerBase;
      2'b10:   base_addr = AddrDateBase;
      2'b11:   base_addr = AddrTimeBase;
      default: base_addr = 8'h00;
    endcase
  end

  // Lowest pending field first.
  always_comb begin
    if (dirty_q[0])      wr_idx = 2'd0;
    else if (dirty_q[1]) wr_idx = 2'd1;
    else                 wr_idx = 2'd2;
  end

  always_comb begin
    state_d    = state_q;
    act_mode_d = act_mode_q;
    dirty_d    = dirty_q;
    shadow_d   = shadow_q;
    wr_req_d   = wr_req_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      StIdle: begin
        if (load_en_i) shadow_d = {ld_f2_i, ld_f1_i, ld_f0_i};
        if (mode_i != 2'b00) begin
          act_mode_d = mode_i;
          dirty_d    = 3'b000;
          state_d    = StEdit;
        end
      end

      StEdit: begin
        if (mode_i != act_mode_q) begin
          state_d = (dirty_q != 3'b000) ? StWrSetup : StIdle;
        end else if ((field_i != 2'b00) && (btn_up_i ^ btn_down_i)) begin
          case (field_i)
            2'b01: begin
              shadow_d[0] = new_val;
              dirty_d[0]  = 1'b1;
            end
            2'b10: begin
              shadow_d[1] = new_val;
              dirty_d[1]  = 1'b1;
            end
            2'b11: begin
              shadow_d[2] = new_val;
              dirty_d[2]  = 1'b1;
            end
            default: ;
          endcase
        end
      end

      StWrSetup: begin
        wr_addr_d = base_addr + {6'd0, wr_idx};
        wr_data_d = shadow_q[wr_idx];
        wr_req_d  = 1'b1;
        state_d   = StWrWait;
      end

      StWrWait: begin
        if (wr_ack_i) begin
          dirty_d[wr_idx] = 1'b0;
          wr_req_d        = 1'b0;
          state_d         = (dirty_d != 3'b000) ? StWrSetup : StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      act_mode_q <= 2'b00;
      dirty_q    <= 3'b000;
      shadow_q   <= '0;
      wr_req_q   <= 1'b0;
      wr_addr_q  <= 8'h00;
      wr_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      act_mode_q <= act_mode_d;
      dirty_q    <= dirty_d;
      shadow_q   <= shadow_d;
      wr_req_q   <= wr_req_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_req_o  = wr_req_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign f0_o      = shadow_q[0];
  assign f1_o      = shadow_q[1];
  assign f2_o      = shadow_q[2];
  assign busy_o    = (state_q == StWrSetup) || (state_q == StWrWait);

endmodule

// File: tb/tb_rtc_edit_sequencer.sv
// Table-driven bench for rtc_edit_sequencer; each row drives one cycle and checks the outputs
// registered at the following edge.
module tb_rtc_edit_sequencer;

  logic       clk = 1'b0;
  logic       reset, btn_up, btn_down, load_en, wr_ack;
  logic [1:0] mode, field;
  logic [7:0] ld_f0, ld_f1, ld_f2;
  logic       wr_req, busy;
  logic [7:0] wr_addr, wr_data, f0, f1, f2;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  rtc_edit_sequencer dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .mode_i     (mode),
    .field_i    (field),
    .btn_up_i   (btn_up),
    .btn_down_i (btn_down),
    .load_en_i  (load_en),
    .ld_f0_i    (ld_f0),
    .ld_f1_i    (ld_f1),
    .ld_f2_i    (ld_f2),
    .wr_ack_i   (wr_ack),
    .wr_req_o   (wr_req),
    .wr_addr_o  (wr_addr),
    .wr_data_o  (wr_data),
    .f0_o       (f0),
    .f1_o       (f1),
    .f2_o       (f2),
    .busy_o     (busy)
  );

  typedef struct {
    logic       rst;
    logic [1:0] mode;
    logic [1:0] field;
    logic       up;
    logic       dn;
    logic       le;
    logic [7:0] l0, l1, l2;
    logic       ack;
    logic [7:0] e0, e1, e2;
    logic       ereq;
    logic [7:0] eaddr, edata;
    logic       ebusy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic [1:0] m, input logic [1:0] fld,
                              input logic up, input logic dn, input logic le,
                              input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                              input logic ack,
                              input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                              input logic er, input logic [7:0] ea, input logic [7:0] ed,
                              input logic eb);
    vec_t t;
    t.rst = rst; t.mode = m; t.field = fld; t.up = up; t.dn = dn; t.le = le;
    t.l0 = l0; t.l1 = l1; t.l2 = l2; t.ack = ack;
    t.e0 = e0; t.e1 = e1; t.e2 = e2; t.ereq = er; t.eaddr = ea; t.edata = ed; t.ebusy = eb;
    return t;
  endfunction

  // Packed view: {f0, f1, f2, wr_req, wr_addr, wr_data, busy}
  task automatic check(input string name, input logic [41:0] exp);
    logic [41:0] act;
    act = {f0, f1, f2, wr_req, wr_addr, wr_data, busy};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got f0/f1/f2=%h/%h/%h req=%b addr=%h data=%h busy=%b, want %h/%h/%h req=%b addr=%h data=%h busy=%b",
                  name, act[41:34], act[33:26], act[25:18], act[17], act[16:9], act[8:1], act[0],
                  exp[41:34], exp[33:26], exp[25:18], exp[17], exp[16:9], exp[8:1], exp[0]);
  endtask

  task automatic drive(input logic rst, input logic [1:0] m, input logic [1:0] fld,
                       input logic up, input logic dn, input logic le, input logic [7:0] l0,
                       input logic [7:0] l1, input logic [7:0] l2, input logic ack);
    reset = rst; mode = m; field = fld; btn_up = up; btn_down = dn; load_en = le;
    ld_f0 = l0; ld_f1 = l1; ld_f2 = l2; wr_ack = ack;
  endtask

  initial begin
    drive(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);

    // T1: reset, load in IDLE
    vecs.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 8'h12, 8'h34, 8'h56, 1'b0,
                      8'h12, 8'h34, 8'h56, 1'b0, 8'h00, 8'h00, 1'b0));
    // T2: time hours wrap 23->00->23, single write-back to 0x23
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 8'h30, 8'h45, 8'h23, 1'b0,
                      8'h30, 8'h45, 8'h23, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h30, 8'h45, 8'h23, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h30, 8'h45, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h30, 8'h45, 8'h23, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h30, 8'h45, 8'h23, 1'b0, 8'h00, 8'h00, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h30, 8'h45, 8'h23, 1'b1, 8'h23, 8'h23, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h30, 8'h45, 8'h23, 1'b1, 8'h23, 8'h23, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1,
                      8'h30, 8'h45, 8'h23, 1'b0, 8'h23, 8'h23, 1'b0));
    // stray ack in IDLE
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1,
                      8'h30, 8'h45, 8'h23, 1'b0, 8'h23, 8'h23, 1'b0));
    // T3: date month 12->01, day 01->31, two writes with one gap cycle
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 8'h07, 8'h12, 8'h01, 1'b0,
                      8'h07, 8'h12, 8'h01, 1'b0, 8'h23, 8'h23, 1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h07, 8'h12, 8'h01, 1'b0, 8'h23, 8'h23, 1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h07, 8'h01, 8'h01, 1'b0, 8'h23, 8'h23, 1'b0));
    vecs.push_back(mk(1'b0, 2'b10, 2'b11, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h07, 8'h01, 8'h31, 1'b0, 8'h23, 8'h23, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h07, 8'h01, 8'h31, 1'b0, 8'h23, 8'h23, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h07, 8'h01, 8'h31, 1'b1, 8'h25, 8'h01, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1,
                      8'h07, 8'h01, 8'h31, 1'b0, 8'h25, 8'h01, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h07, 8'h01, 8'h31, 1'b1, 8'h26, 8'h31, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1,
                      8'h07, 8'h01, 8'h31, 1'b0, 8'h26, 8'h31, 1'b0));
    // T4: both buttons -> no edit, no write
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 8'h59, 8'h00, 8'h00, 1'b0,
                      8'h59, 8'h00, 8'h00, 1'b0, 8'h26, 8'h31, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h59, 8'h00, 8'h00, 1'b0, 8'h26, 8'h31, 1'b0));
    vecs.push_back(mk(1'b0, 2'b01, 2'b01, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h59, 8'h00, 8'h00, 1'b0, 8'h26, 8'h31, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h59, 8'h00, 8'h00, 1'b0, 8'h26, 8'h31, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h59, 8'h00, 8'h00, 1'b0, 8'h26, 8'h31, 1'b0));
    // digit carry 09<->10, hours 00->23, field=00 and load_en ignored in EDIT
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 8'h09, 8'h10, 8'h00, 1'b0,
                      8'h09, 8'h10, 8'h00, 1'b0, 8'h26, 8'h31, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h09, 8'h10, 8'h00, 1'b0, 8'h26, 8'h31, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 2'b01, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h10, 8'h10, 8'h00, 1'b0, 8'h26, 8'h31, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 2'b10, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h10, 8'h09, 8'h00, 1'b0, 8'h26, 8'h31, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h09, 8'h09, 8'h00, 1'b0, 8'h26, 8'h31, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 2'b11, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h09, 8'h09, 8'h23, 1'b0, 8'h26, 8'h31, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h09, 8'h09, 8'h23, 1'b0, 8'h26, 8'h31, 1'b0));
    vecs.push_back(mk(1'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 8'h77, 8'h77, 8'h77, 1'b0,
                      8'h09, 8'h09, 8'h23, 1'b0, 8'h26, 8'h31, 1'b0));
    // three dirty fields; T6: reset while the second request is pending
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h09, 8'h09, 8'h23, 1'b0, 8'h26, 8'h31, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h09, 8'h09, 8'h23, 1'b1, 8'h21, 8'h09, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1,
                      8'h09, 8'h09, 8'h23, 1'b0, 8'h21, 8'h09, 1'b1));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h09, 8'h09, 8'h23, 1'b1, 8'h22, 8'h09, 1'b1));
    vecs.push_back(mk(1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));
    vecs.push_back(mk(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0,
                      8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].mode, vecs[i].field, vecs[i].up, vecs[i].dn, vecs[i].le,
            vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].ack);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {vecs[i].e0, vecs[i].e1, vecs[i].e2, vecs[i].ereq,
                                     vecs[i].eaddr, vecs[i].edata, vecs[i].ebusy});
    end

    // T5: timer seconds 00->59, ack held off 5 cycles while buttons/load/mode poke the DUT
    drive(1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 2'b01, 2'b01, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("t5_req", {8'h59, 8'h00, 8'h00, 1'b1, 8'h41, 8'h59, 1'b1});
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33, 1'b0);
      @(posedge clk); #1;
      check($sformatf("t5_hold%0d", k), {8'h59, 8'h00, 8'h00, 1'b1, 8'h41, 8'h59, 1'b1});
    end
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
    @(posedge clk); #1;
    check("t5_ack", {8'h59, 8'h00, 8'h00, 1'b0, 8'h41, 8'h59, 1'b0});
    drive(1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
    @(posedge clk); #1;
    check("t5_idle", {8'h59, 8'h00, 8'h00, 1'b0, 8'h41, 8'h59, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
